udp_rx_packer: RTL and testbench

//  Downstream of the UDP receive parser. Packs the parser's payload nibble stream (fifo_en/fifo_data, low nibble first) into bytes.

---
 rtl/udp_rx_packer.sv | 232 +++++++++++++++++++++++
 tb/tb_udp_rx_packer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/udp_rx_packer.sv
// Packs the UDP payload nibble stream into sop/eop tagged bytes behind a show-ahead FIFO.
// Optional frame length report: define RX_PKT_LEN_EN to add pkt_len/pkt_len_vld.
module udp_rx_packer #(
    parameter int FIFO_AW = 4,
    parameter int LEN_W   = 11
) (
    input  logic             r_clk,
    input  logic             rst_n,
    input  logic             fifo_en,
    input  logic [3:0]       fifo_data,
    output logic [7:0]       m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_sop,
    output logic             m_eop,
    output logic             m_err,
    output logic             odd_err,
    output logic             overflow
`ifdef RX_PKT_LEN_EN
    ,
    output logic [LEN_W-1:0] pkt_len,
    output logic             pkt_len_vld
`endif
);
    // state  | meaning
    // S_IDLE | between frames, waiting for first nibble
    // S_HI   | low nibble latched, waiting for high nibble
    // S_LO   | byte complete, waiting for next low nibble or frame end
    // S_DROP | discarding rest of frame (overflow or pending terminator)
    typedef enum logic [1:0] {S_IDLE, S_HI, S_LO, S_DROP} state_t;

    typedef struct packed {
        logic       err;
        logic       sop;
        logic       eop;
        logic [7:0] data;
    } ent_t;

    localparam int DEPTH = 1 << FIFO_AW;

    state_t             state_q, state_d;
    logic [3:0]         lo_q, lo_d;
    logic               first_q, first_d;
    logic               stg_vld_q, stg_vld_d;
    logic               stg_sop_q, stg_sop_d;
    logic [7:0]         stg_data_q, stg_data_d;
    logic               pend_err_q, pend_err_d;
    logic               drop_err_q, drop_err_d;
    logic               odd_err_q, odd_err_d;
    logic               overflow_q, overflow_d;

    ent_t               mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   cnt_q, cnt_d;
    logic               full;
    logic               pop;
    logic               term_req;
    logic               data_req;
    logic               push_en;
    ent_t               data_ent;
    ent_t               push_ent;
    ent_t               head;

    assign full     = (cnt_q == (FIFO_AW+1)'(DEPTH));
    assign term_req = pend_err_q && !full;

    always_comb begin
        state_d    = state_q;
        lo_d       = lo_q;
        first_d    = first_q;
        stg_vld_d  = stg_vld_q;
        stg_sop_d  = stg_sop_q;
        stg_data_d = stg_data_q;
        pend_err_d = pend_err_q;
        drop_err_d = drop_err_q;
        odd_err_d  = 1'b0;
        overflow_d = 1'b0;
        data_req   = 1'b0;
        data_ent   = '0;
        if (term_req) pend_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fifo_en) begin
                    if (pend_err_q) begin
                        drop_err_d = 1'b0;
                        state_d    = S_DROP;
                    end else begin
                        lo_d    = fifo_data;
                        first_d = 1'b1;
                        state_d = S_HI;
                    end
                end
            end
            S_HI: begin
                if (fifo_en) begin
                    data_req   = stg_vld_q;
                    data_ent   = '{err: 1'b0, sop: stg_sop_q, eop: 1'b0, data: stg_data_q};
                    stg_vld_d  = 1'b1;
                    stg_sop_d  = first_q;
                    stg_data_d = {fifo_data, lo_q};
                    first_d    = 1'b0;
                    state_d    = S_LO;
                end else begin
                    odd_err_d = 1'b1;
                    data_req  = stg_vld_q;
                    data_ent  = '{err: 1'b0, sop: stg_sop_q, eop: 1'b1, data: stg_data_q};
                    stg_vld_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            S_LO: begin
                if (fifo_en) begin
                    lo_d    = fifo_data;
                    state_d = S_HI;
                end else begin
                    data_req  = stg_vld_q;
                    data_ent  = '{err: 1'b0, sop: stg_sop_q, eop: 1'b1, data: stg_data_q};
                    stg_vld_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                if (!fifo_en) begin
                    if (drop_err_q) pend_err_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
        endcase
        // A drop on the frame-end push has no nibbles left to discard, so arm the terminator directly.
        if (data_req && full) begin
            overflow_d = 1'b1;
            stg_vld_d  = 1'b0;
            if (state_d == S_IDLE) begin
                pend_err_d = 1'b1;
            end else begin
                drop_err_d = 1'b1;
                state_d    = S_DROP;
            end
        end
    end

    assign push_en  = term_req || (data_req && !full);
    assign push_ent = term_req ? '{err: 1'b1, sop: 1'b0, eop: 1'b1, data: 8'h00} : data_ent;
    assign pop      = m_valid && m_ready;

    always_comb begin
        cnt_d = cnt_q;
        case ({push_en, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge r_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            lo_q       <= '0;
            first_q    <= 1'b0;
            stg_vld_q  <= 1'b0;
            stg_sop_q  <= 1'b0;
            stg_data_q <= '0;
            pend_err_q <= 1'b0;
            drop_err_q <= 1'b0;
            odd_err_q  <= 1'b0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            lo_q       <= lo_d;
            first_q    <= first_d;
            stg_vld_q  <= stg_vld_d;
            stg_sop_q  <= stg_sop_d;
            stg_data_q <= stg_data_d;
            pend_err_q <= pend_err_d;
            drop_err_q <= drop_err_d;
            odd_err_q  <= odd_err_d;
            overflow_q <= overflow_d;
            cnt_q      <= cnt_d;
            if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge r_clk) begin
        if (push_en) mem_q[wr_ptr_q] <= push_ent;
    end

    assign head     = mem_q[rd_ptr_q];
    assign m_valid  = (cnt_q != '0);
    assign m_data   = m_valid ? head.data : 8'h00;
    assign m_sop    = m_valid && head.sop;
    assign m_eop    = m_valid && head.eop;
    assign m_err    = m_valid && head.err;
    assign odd_err  = odd_err_q;
    assign overflow = overflow_q;

`ifdef RX_PKT_LEN_EN
    logic             data_push_en;
    logic [LEN_W-1:0] len_cnt_q, len_cnt_d;
    logic [LEN_W-1:0] pkt_len_q;
    logic             pkt_len_vld_q;

    assign data_push_en = data_req && !full;

    always_comb begin
        len_cnt_d = len_cnt_q;
        if (data_push_en) begin
            if (data_ent.sop)    len_cnt_d = LEN_W'(1);
            else if (!(&len_cnt_q)) len_cnt_d = len_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge r_clk or negedge rst_n) begin
        if (!rst_n) begin
            len_cnt_q     <= '0;
            pkt_len_q     <= '0;
            pkt_len_vld_q <= 1'b0;
        end else begin
            len_cnt_q     <= len_cnt_d;
            pkt_len_vld_q <= data_push_en && data_ent.eop;
            if (data_push_en && data_ent.eop) pkt_len_q <= len_cnt_d;
        end
    end

    assign pkt_len     = pkt_len_q;
    assign pkt_len_vld = pkt_len_vld_q;
`endif

endmodule

// File: tb/tb_udp_rx_packer.sv
// Scoreboard bench for udp_rx_packer (depth-4 FIFO); covers pkt_len when RX_PKT_LEN_EN is defined.
module tb_udp_rx_packer;
    localparam int AW = 2;
    localparam int LW = 11;

    logic          r_clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_en = 1'b0;
    logic [3:0]    fifo_data = 4'h0;
    logic          m_ready = 1'b1;
    logic [7:0]    m_data;
    logic          m_valid, m_sop, m_eop, m_err, odd_err, overflow;
`ifdef RX_PKT_LEN_EN
    logic [LW-1:0] pkt_len;
    logic          pkt_len_vld;
`endif

    udp_rx_packer #(.FIFO_AW(AW), .LEN_W(LW)) dut (
        .r_clk(r_clk), .rst_n(rst_n), .fifo_en(fifo_en), .fifo_data(fifo_data),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_sop(m_sop),
        .m_eop(m_eop), .m_err(m_err), .odd_err(odd_err), .overflow(overflow)
`ifdef RX_PKT_LEN_EN
        , .pkt_len(pkt_len), .pkt_len_vld(pkt_len_vld)
`endif
    );

    always #5 r_clk = ~r_clk;

    int          errors = 0;
    int          checks = 0;
    logic [10:0] exp_q[$];
    int          len_q[$];
    int          odd_cnt = 0;
    int          ovf_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Entries are {err,sop,eop,data}; a pop happens on the next rising edge.
    always @(negedge r_clk) begin
        if (rst_n) begin
            if (odd_err)  odd_cnt++;
            if (overflow) ovf_cnt++;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) check("unexpected_entry", {m_err, m_sop, m_eop, m_data}, 32'hFFFF);
                else check("entry", {m_err, m_sop, m_eop, m_data}, exp_q.pop_front());
            end else if (!m_valid) begin
                check("idle_zero", {m_err, m_sop, m_eop, m_data}, 0);
            end
`ifdef RX_PKT_LEN_EN
            if (pkt_len_vld) begin
                if (len_q.size() == 0) check("unexpected_len", pkt_len, 32'hFFFF);
                else check("pkt_len", pkt_len, len_q.pop_front());
            end
`endif
        end
    end

    task automatic send_frame(input logic [127:0] nibs, input int n, input bit model);
        int nb;
        nb = n / 2;
        if (model) begin
            for (int i = 0; i < nb; i++)
                exp_q.push_back({1'b0, (i == 0), (i == nb - 1), nibs[8*i +: 8]});
            if (nb > 0) len_q.push_back(nb);
        end
        for (int i = 0; i < n; i++) begin
            @(posedge r_clk); #1;
            fifo_en   = 1'b1;
            fifo_data = nibs[4*i +: 4];
        end
        @(posedge r_clk); #1;
        fifo_en = 1'b0;
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 200; c++) begin
            @(posedge r_clk); #1;
            if (exp_q.size() == 0 && !m_valid) break;
        end
        repeat (3) @(posedge r_clk);
        #1;
        check("drain_left", exp_q.size(), 0);
        check("drain_valid", m_valid, 0);
    endtask

    initial begin
        #2;
        check("rst_out", {m_valid, m_err, m_sop, m_eop, m_data, odd_err, overflow}, 0);
`ifdef RX_PKT_LEN_EN
        check("rst_len", {pkt_len, pkt_len_vld}, 0);
`endif
        repeat (2) @(posedge r_clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge r_clk);

        // two bytes, even end
        send_frame(128'hC3A5, 4, 1'b1);
        wait_drain();

        // odd end: F discarded
        send_frame(128'hF21, 3, 1'b1);
        wait_drain();
        check("odd_after_t2", odd_cnt, 1);

        // overflow with consumer stalled
        m_ready = 1'b0;
        exp_q.push_back({3'b010, 8'h11});
        exp_q.push_back({3'b000, 8'h22});
        exp_q.push_back({3'b000, 8'h33});
        exp_q.push_back({3'b000, 8'h44});
        exp_q.push_back({3'b101, 8'h00});
        send_frame(128'hCCBB_AA99_8877_6655_4433_2211, 24, 1'b0);
        repeat (5) @(posedge r_clk);
        #1;
        check("ovf_pulses", ovf_cnt, 1);
        check("ovf_held_valid", m_valid, 1);
        check("ovf_head", {m_err, m_sop, m_eop, m_data}, {3'b010, 8'h11});
        m_ready = 1'b1;
        wait_drain();
        check("ovf_pulses_end", ovf_cnt, 1);

        // back-to-back frames, one idle cycle apart
        send_frame(128'h4321, 4, 1'b1);
        send_frame(128'hCBA987, 6, 1'b1);
        send_frame(128'hEDFE, 4, 1'b1);
        wait_drain();

        // reset mid-frame with three entries queued
        m_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(posedge r_clk); #1;
            fifo_en   = 1'b1;
            fifo_data = 4'(i + 1);
        end
        check("pre_rst_valid", m_valid, 1);
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", m_valid, 0);
        fifo_en = 1'b0;
        @(posedge r_clk); #1;
        check("rst_next_valid", {m_valid, m_data}, 0);
        rst_n   = 1'b1;
        m_ready = 1'b1;
        send_frame(128'h65, 2, 1'b1);
        wait_drain();

        // single-nibble frame
        send_frame(128'h7, 1, 1'b1);
        repeat (4) @(posedge r_clk);
        #1;
        check("single_valid", m_valid, 0);
        check("odd_total", odd_cnt, 2);
        check("ovf_total", ovf_cnt, 1);
        check("exp_left", exp_q.size(), 0);
`ifdef RX_PKT_LEN_EN
        check("len_left", len_q.size(), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
